// File: rtl/q_8_42_controller_if.sv
// Operand/result handshake bundle for the count-ones controller.
// The controller uses the slave modport; the requester/consumer side uses master.
interface q_8_42_controller_if #(
   parameter int data_size = 8,
   parameter int r2_size   = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [data_size-1:0] in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [r2_size-1:0]   out_cnt;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_cnt
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_cnt
   );
endinterface

// File: rtl/q_8_42_controller.sv
// Sequencer for the count-ones datapath: load, scan until r1 is empty, return r2.
// Optional SCAN-cycle counter output out_cycles enabled by Q_8_42_CYCLE_CNT_EN.
module q_8_42_controller #(
   parameter int data_size = 8,
   parameter int r2_size   = 4
`ifdef Q_8_42_CYCLE_CNT_EN
   ,
   parameter int cyc_size  = 4
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   q_8_42_controller_if.slave   bus,
   input  logic                 abort,
   output logic [data_size-1:0] dp_data,
   output logic                 load_regs,
   output logic                 incr_and_shift,
   output logic                 shift_only,
   input  logic                 zero,
   input  logic                 msb,
   input  logic [r2_size-1:0]   cnt
`ifdef Q_8_42_CYCLE_CNT_EN
   ,
   output logic [cyc_size-1:0]  out_cycles
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   state_t state;
   logic   ready;
   logic   accept;

`ifdef Q_8_42_CYCLE_CNT_EN
   logic [cyc_size-1:0] cyc_cnt;
`endif

   assign dp_data      = bus.in_data;
   assign bus.in_ready = ready;
   assign accept       = bus.in_valid & ready;
   assign load_regs    = accept;

   // rst gates everything so no control leaks out while reset is held
   always_comb begin
      ready          = 1'b0;
      incr_and_shift = 1'b0;
      shift_only     = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: ready = 1'b1;
            SCAN: begin
               if (!abort && !zero) begin
                  if (msb) incr_and_shift = 1'b1;
                  else     shift_only     = 1'b1;
               end
            end
            DONE: ready = bus.out_ready;
            default: ready = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         bus.out_valid <= 1'b0;
         bus.out_cnt   <= '0;
`ifdef Q_8_42_CYCLE_CNT_EN
         cyc_cnt       <= '0;
         out_cycles    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= SCAN;
`ifdef Q_8_42_CYCLE_CNT_EN
                  cyc_cnt <= '0;
`endif
               end
            end
            SCAN: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
`ifdef Q_8_42_CYCLE_CNT_EN
                  cyc_cnt <= cyc_cnt + 1'b1;
`endif
                  if (zero) begin
                     state         <= DONE;
                     bus.out_valid <= 1'b1;
                     bus.out_cnt   <= cnt;
`ifdef Q_8_42_CYCLE_CNT_EN
                     // the zero-detect cycle itself is counted
                     out_cycles    <= cyc_cnt + 1'b1;
`endif
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  if (accept) begin
                     state <= SCAN;
`ifdef Q_8_42_CYCLE_CNT_EN
                     cyc_cnt <= '0;
`endif
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state         <= IDLE;
               bus.out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/q_8_42_controller.md
Name: q_8_42_controller

Overview:
- FSM controller that sequences the count-ones datapath (r1 shift register plus r2 counter).
- Accepts an operand over a valid/ready handshake and issues exactly one datapath control per cycle: load_regs, incr_and_shift or shift_only.
- Detects completion from the datapath status (zero) and returns the captured count over a second valid/ready handshake.
- Sits between the requesting block and the datapath. At top level the datapath's rst_b is driven by ~rst.

Parameters:
- data_size, 8, operand width; must match the datapath.
- r2_size, 4, count width; must hold data_size, i.e. >= $clog2(data_size+1).
- cyc_size, 4, scan-cycle counter width (optional feature only); must hold data_size+1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  requester presents operand
- in_ready  output  1  controller accepts operand this cycle
- in_data  input  data_size  operand
- abort  input  1  synchronous cancel of an in-flight operation
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_cnt  output  r2_size  number of ones in the accepted operand
- dp_data  output  data_size  to datapath data_in; combinational copy of in_data
- load_regs  output  1  to datapath
- incr_and_shift  output  1  to datapath
- shift_only  output  1  to datapath
- zero  input  1  from datapath: r1 == 0
- msb  input  1  from datapath: r1[data_size-1]
- cnt  input  r2_size  from datapath count

Behaviour:
- Reset (async, rst=1): state=IDLE, out_valid=0, out_cnt=0, in_ready=0 while rst is asserted. All datapath controls are 0.
- States: IDLE, SCAN, DONE. State and out_cnt are registered. Controls and in_ready are combinational from state and inputs (Mealy).
- accept = in_valid & in_ready. load_regs = accept.
- IDLE:
  - in_ready=1.
  - On accept, go to SCAN; the datapath loads in_data at the same edge.
- SCAN:
  - in_ready=0.
  - If abort=1: all controls 0, next state IDLE, no result. abort has priority over zero.
  - Else if zero=1: no control asserted; next state DONE; out_cnt<=cnt at that edge.
  - Else if msb=1: incr_and_shift=1, stay in SCAN.
  - Else: shift_only=1, stay in SCAN.
- DONE:
  - out_valid=1; out_cnt is held stable until the handshake completes.
  - in_ready=out_ready. This gives back-to-back operation: if out_ready & in_valid, load and go to SCAN; if only out_ready, go to IDLE.
  - abort is ignored in IDLE and DONE.
- Latency is counted in edges from the accept edge to out_valid=1: 2 + S, where S = data_size - (index of lowest set bit). S = 0 for an operand of 0. Examples with data_size=8: 0x00 gives 2, 0x80 gives 3, 0x01 gives 10.
- Invariants:
  - At most one of load_regs, incr_and_shift, shift_only is high in any cycle.
  - No control is asserted during reset.
  - out_valid never drops without out_ready.
- Reset mid-SCAN returns to IDLE immediately, with out_valid=0. The datapath is reset through the same net.

Optional Feature:
- Macro: Q_8_42_CYCLE_CNT_EN.
- Defined:
  - Adds output out_cycles [cyc_size] = number of SCAN cycles (including the final zero-detect cycle) spent on the operation.
  - Internal counter: cleared on accept, incremented each SCAN cycle.
  - Captured with out_cnt and held through DONE. Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset check: assert rst mid-idle → out_valid=0, out_cnt=0, all controls 0. After release, in_ready=1.
- Operand 0xB5, out_ready=1 → out_valid 10 edges after accept. out_cnt=5; exactly 5 incr_and_shift and 3 shift_only pulses. out_cycles=9 with the macro.
- Operand 0x00 → out_valid 2 edges after accept, out_cnt=0. Operand 0xFF → out_cnt=8 after 10 edges.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_valid and out_cnt=3 (operand 0x07) stay stable. A new in_valid is not accepted (in_ready=0) until out_ready=1.
- Back-to-back: in DONE, out_ready=1 and in_valid=1 with 0x80 → load_regs in the same cycle. Next result out_cnt=1, 3 edges later.
- Abort and reset: abort during SCAN of 0x01 → IDLE next edge, no out_valid. Async rst pulse mid-SCAN → state IDLE, controls 0 without waiting for a clock edge.
